// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller.
// Holds the FSM state type, default parameter values and the width of the
// per-half-word wait counter.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0]  BASE_ADDR_DEFAULT   = 32'd1024;
    localparam int unsigned  SRAM_AW_DEFAULT     = 18;
    localparam int unsigned  WAIT_CYCLES_DEFAULT = 2;

    // Wide enough for the largest legal WAIT_CYCLES (15).
    localparam int unsigned  WCNT_W = 4;

    // Counter value reached n cycles before the end of a half-word phase
    // (n=1 -> last cycle, n=2 -> cycle before last).
    function automatic logic [WCNT_W-1:0] count_before_end(input int unsigned wait_cycles,
                                                           input int unsigned n);
        return WCNT_W'(wait_cycles - n);
    endfunction

endpackage

// File: rtl/sram_controller_wait_counter.sv
// sram_wait_counter: counts clock cycles inside one half-word SRAM access.
// Ports:
//   clk, rst  - clock, synchronous active-low reset
//   clear     - force count to 0 on the next edge (has priority over enable)
//   enable    - increment count
//   count     - current cycle index within the phase (0..WAIT_CYCLES-1)
//   tc        - terminal count: this is the last cycle of the phase
module sram_wait_counter
    import sram_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    output logic [WCNT_W-1:0] count,
    output logic              tc
);

    localparam logic [WCNT_W-1:0] LAST = count_before_end(WAIT_CYCLES, 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/sram_controller.sv
// sram_controller: serves 32-bit load/store requests from the MEM stage
// against an external 16-bit asynchronous SRAM, one word = two half-word
// accesses (low half first). ready low stalls the pipeline.
// Ports:
//   clk, rst              - clock, synchronous active-low reset
//   rdEn, wrEn            - load / store request (store wins if both)
//   address, writeData    - byte address and store data
//   readData              - registered load result
//   ready                 - 1 when idle with no request, or in the DONE cycle
//   sram_addr             - half-word address {word[SRAM_AW:2], half}
//   sram_dq_out/oe        - write data and its output enable
//   sram_dq_in            - read data from SRAM
//   sram_we_n             - active-low write strobe
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned SRAM_AW     = SRAM_AW_DEFAULT,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT   // legal 2..15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdEn,
    input  logic               wrEn,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    // Counter value of the cycle before the last one in a phase; the strobe
    // for the next cycle is decided from it because outputs are registered.
    localparam logic [WCNT_W-1:0] PRE_LAST = count_before_end(WAIT_CYCLES, 2);

    state_t             state;
    logic               is_write;
    logic [SRAM_AW-2:0] word_idx;
    logic [31:0]        wdata;
    logic [WCNT_W-1:0]  wcnt;
    logic               tc;
    logic               busy;
    logic               request;

    // Only the low SRAM_AW+1 bits of (address - BASE_ADDR) are ever used, and
    // modular subtraction of the truncated operands yields the same bits.
    logic [SRAM_AW:0]   word_off;
    logic               unused_bits;

    assign word_off    = address[SRAM_AW:0] - BASE_ADDR[SRAM_AW:0];
    assign unused_bits = ^{address[31:SRAM_AW+1], word_off[1:0]};

    assign busy    = (state == ST_LO) || (state == ST_HI);
    assign request = rdEn | wrEn;

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk    (clk),
        .rst    (rst),
        .clear  (!busy || tc),
        .enable (busy),
        .count  (wcnt),
        .tc     (tc)
    );

    always_comb begin
        ready = 1'b0;
        case (state)
            ST_IDLE: ready = !request;
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // SRAM pin values are computed for the state being entered, so they are
    // registered and change together with the state/counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            is_write    <= 1'b0;
            word_idx    <= '0;
            wdata       <= '0;
            readData    <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (request) begin
                        state      <= ST_LO;
                        is_write   <= wrEn;
                        word_idx   <= word_off[SRAM_AW:2];
                        wdata      <= writeData;
                        sram_addr  <= {word_off[SRAM_AW:2], 1'b0};
                        sram_dq_oe <= wrEn;
                        sram_we_n  <= !wrEn;
                        if (wrEn) begin
                            sram_dq_out <= writeData[15:0];
                        end
                    end
                end
                ST_LO: begin
                    if (tc) begin
                        state      <= ST_HI;
                        sram_addr  <= {word_idx, 1'b1};
                        sram_dq_oe <= is_write;
                        sram_we_n  <= !is_write;
                        if (is_write) begin
                            sram_dq_out <= wdata[31:16];
                        end else begin
                            readData[15:0] <= sram_dq_in;
                        end
                    end else begin
                        // Strobe released for the last cycle of the phase.
                        sram_we_n <= !(is_write && (wcnt != PRE_LAST));
                    end
                end
                ST_HI: begin
                    if (tc) begin
                        state      <= ST_DONE;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        if (!is_write) begin
                            readData[31:16] <= sram_dq_in;
                        end
                    end else begin
                        sram_we_n <= !(is_write && (wcnt != PRE_LAST));
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
